// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. One full-adder cell and a registered carry
// produce one sum bit per clock, LSB first. Operands come in and the result
// goes out through valid/ready handshakes.

// Single-bit combinational full adder, shared by every bit position.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// state | meaning
// IDLE  | waiting for an operand set; in_ready high
// RUN   | adding one bit per clock, LSB first
// DONE  | result presented on sum/cout; waiting for out_ready
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  // A one-bit adder has nothing to shift, so it gets its own branch.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_next = fa_s;
    end else begin : g_wn
      assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // in_ready is decoded straight from the state register.
  assign in_ready = (state == IDLE);

  // Sequencer: operand capture, bit-serial add, result hold and handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            sum_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          carry  <= fa_c;
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum       <= sum_next;
            cout      <= fa_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
